tdc_multichan_stamper: RTL and testbench

TDC_MULTICHAN_STAMPER -- requirements
Module: tdc_multichan_stamper

---
 rtl/tdc_multichan_stamper_pkg.sv | 34 +++
 rtl/tdc_thermo_encoder.sv | 50 +++++
 rtl/tdc_multichan_stamper.sv | 236 +++++++++++++++++++++++
 tb/tb_tdc_multichan_stamper.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_multichan_stamper_pkg.sv
// Shared TDC definitions: width derivations and the output word layout.
//
// Output word layout, MSB to LSB:
//   { channel [CH_W-1:0], coarse [COARSE_W-1:0], fine [FINE_W-1:0] }
// The *_lsb_f helpers give the bit offset of each field in that word.
package tdc_multichan_stamper_pkg;

  // A fine code counts set taps, so it must represent 0 .. NUM_TAPS inclusive.
  function automatic int fine_w_f(input int num_taps);
    return $clog2(num_taps + 32'sd1);
  endfunction

  // A single-channel build still carries a one-bit channel field.
  function automatic int ch_w_f(input int num_ch);
    return (num_ch > 32'sd1) ? $clog2(num_ch) : 32'sd1;
  endfunction

  function automatic int word_w_f(input int ch_w, input int coarse_w, input int fine_w);
    return ch_w + coarse_w + fine_w;
  endfunction

  function automatic int fine_lsb_f();
    return 32'sd0;
  endfunction

  function automatic int coarse_lsb_f(input int fine_w);
    return fine_w;
  endfunction

  function automatic int ch_lsb_f(input int coarse_w, input int fine_w);
    return coarse_w + fine_w;
  endfunction

endpackage

// File: rtl/tdc_thermo_encoder.sv
// Bubble-tolerant thermometer encoder for one delay line.
// The fine code is the population count of the tap snapshot, so a stray
// zero (bubble) inside the thermometer costs one LSB instead of
// corrupting the code. The result register loads only on the capture
// strobe, which lets it act as the fine half of the channel's pending slot.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   load  - capture strobe; the register keeps its value while low
//   taps  - delay-line snapshot
//   fine  - registered popcount of the last loaded snapshot
module tdc_thermo_encoder
  import tdc_multichan_stamper_pkg::*;
#(
  parameter int NUM_TAPS = 32'sd64,
  parameter int FINE_W   = fine_w_f(NUM_TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NUM_TAPS-1:0] taps,
  output logic [FINE_W-1:0]   fine
);

  logic [FINE_W-1:0] count_s;
  logic [FINE_W-1:0] fine_r;

  // Population count of the snapshot.
  always_comb begin
    count_s = {FINE_W{1'b0}};
    for (int i = 0; i < NUM_TAPS; i++) begin
      count_s = count_s + FINE_W'(taps[i]);
    end
  end

  // Fine-code register, loaded only when the channel captures a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine_r <= {FINE_W{1'b0}};
    end else if (load) begin
      fine_r <= count_s;
    end else begin
      fine_r <= fine_r;
    end
  end

  assign fine = fine_r;

endmodule

// File: rtl/tdc_multichan_stamper.sv
// Multi-channel TDC time stamper.
// Each channel detects rising edges of its (already synchronised) hit
// level. An edge captures the coarse counter and the channel's delay-line
// snapshot into a one-entry pending slot. Pending slots are granted
// round-robin, one per cycle, into a first-word-fall-through output FIFO.
// An edge arriving while its channel's slot is still occupied is dropped
// and reported through the sticky overflow flag.
//
// Ports:
//   iClk      - clock, all state on rising edge
//   iRst_n    - asynchronous active-low reset
//   iEnable   - stamping enable (coarse count and edge capture)
//   iHit      - per-channel hit levels
//   iTaps     - per-channel delay-line snapshots, channel c at [c*NUM_TAPS +: NUM_TAPS]
//   oValid    - output word available
//   iReady    - consumer accepts the output word
//   oChannel  - channel of the output word
//   oCoarse   - coarse timestamp of the output word
//   oFine     - fine timestamp (tap popcount) of the output word
//   oOverflow - sticky: at least one hit was lost
//   iClrOvf   - synchronous clear of oOverflow (loses to a same-cycle loss)
//
// FIFO_DEPTH is assumed to be a power of two and at least 2 so the
// pointers wrap naturally.
module tdc_multichan_stamper
  import tdc_multichan_stamper_pkg::*;
#(
  parameter  int NUM_CH     = 32'sd4,
  parameter  int NUM_TAPS   = 32'sd64,
  parameter  int COARSE_W   = 32'sd16,
  parameter  int FIFO_DEPTH = 32'sd8,
  localparam int FINE_W     = fine_w_f(NUM_TAPS),
  localparam int CH_W       = ch_w_f(NUM_CH)
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iEnable,
  input  logic [NUM_CH-1:0]            iHit,
  input  logic [NUM_CH*NUM_TAPS-1:0]   iTaps,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [CH_W-1:0]              oChannel,
  output logic [COARSE_W-1:0]          oCoarse,
  output logic [FINE_W-1:0]            oFine,
  output logic                         oOverflow,
  input  logic                         iClrOvf
);

  localparam int WORD_W = word_w_f(CH_W, COARSE_W, FINE_W);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 32'sd1;

  logic [COARSE_W-1:0] coarse_r;
  logic [NUM_CH-1:0]   hit_prev_r;
  logic [NUM_CH-1:0]   pend_vld_r;
  logic [COARSE_W-1:0] pend_coarse_r [NUM_CH];
  logic [FINE_W-1:0]   fine_s [NUM_CH];
  logic [NUM_CH-1:0]   edge_s;
  logic [NUM_CH-1:0]   free_s;
  logic [NUM_CH-1:0]   cap_s;
  logic                ovf_evt_s;
  logic                ovf_r;

  logic [CH_W-1:0]     rr_start_r;
  logic [CH_W-1:0]     rr_next_s;
  logic [CH_W-1:0]     grant_ch_s;
  logic                grant_vld_s;

  logic [WORD_W-1:0]   mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W-1:0]   rd_ptr_r;
  logic [ADDR_W-1:0]   rd_ptr_next_s;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_next_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;
  logic [WORD_W-1:0]   push_word_s;
  logic [WORD_W-1:0]   head_next_s;
  logic [WORD_W-1:0]   head_r;
  logic                valid_r;

  // One encoder per channel; its register doubles as the slot's fine field.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_enc
    tdc_thermo_encoder #(
      .NUM_TAPS (NUM_TAPS),
      .FINE_W   (FINE_W)
    ) u_enc (
      .clk   (iClk),
      .rst_n (iRst_n),
      .load  (cap_s[c]),
      .taps  (iTaps[c*NUM_TAPS +: NUM_TAPS]),
      .fine  (fine_s[c])
    );
  end

  // Round-robin search over occupied slots, starting after the last grant.
  always_comb begin
    logic [CH_W-1:0] idx;
    grant_vld_s = 1'b0;
    grant_ch_s  = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_start_r) + k) % NUM_CH);
      if (!grant_vld_s && pend_vld_r[idx]) begin
        grant_vld_s = 1'b1;
        grant_ch_s  = idx;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Push/pop decisions, slot capture/free and the overflow event.
  always_comb begin
    full_s        = (count_r == CNT_W'(FIFO_DEPTH));
    pop_s         = valid_r & iReady;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_s        = grant_vld_s & (~full_s | pop_s);
    edge_s        = {NUM_CH{iEnable}} & iHit & ~hit_prev_r;
    free_s        = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      free_s[c] = push_s & (grant_ch_s == CH_W'(c));
    end
    // A slot leaving this cycle may be refilled by a new edge at once.
    cap_s         = edge_s & (~pend_vld_r | free_s);
    ovf_evt_s     = |(edge_s & pend_vld_r & ~free_s);
    push_word_s   = {grant_ch_s, pend_coarse_r[grant_ch_s], fine_s[grant_ch_s]};
    count_next_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    rd_ptr_next_s = rd_ptr_r + ADDR_W'(pop_s);
    if (grant_ch_s == CH_W'(NUM_CH - 1)) begin
      rr_next_s = {CH_W{1'b0}};
    end else begin
      rr_next_s = grant_ch_s + CH_W'(1'b1);
    end
  end

  // Next head word. When the FIFO would otherwise be empty after the pop,
  // the word being pushed this cycle becomes the head directly.
  always_comb begin
    if (count_next_s == {CNT_W{1'b0}}) begin
      head_next_s = {WORD_W{1'b0}};
    end else if ((count_r - CNT_W'(pop_s)) == {CNT_W{1'b0}}) begin
      head_next_s = push_word_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Coarse counter and previous-hit history.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      coarse_r   <= {COARSE_W{1'b0}};
      hit_prev_r <= {NUM_CH{1'b0}};
    end else begin
      hit_prev_r <= iHit;
      if (iEnable) begin
        coarse_r <= coarse_r + COARSE_W'(1'b1);
      end else begin
        coarse_r <= coarse_r;
      end
    end
  end

  // Pending slots: capture on edge, release when granted.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pend_vld_r <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        pend_coarse_r[c] <= {COARSE_W{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_s[c]) begin
          pend_vld_r[c]    <= 1'b1;
          pend_coarse_r[c] <= coarse_r;
        end else if (free_s[c]) begin
          pend_vld_r[c]    <= 1'b0;
        end else begin
          pend_vld_r[c]    <= pend_vld_r[c];
        end
      end
    end
  end

  // Round-robin pointer and sticky overflow flag.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rr_start_r <= {CH_W{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      if (push_s) begin
        rr_start_r <= rr_next_s;
      end else begin
        rr_start_r <= rr_start_r;
      end
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (iClrOvf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // FIFO storage; contents are never observed while the FIFO is empty.
  always_ff @(posedge iClk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // FIFO pointers, occupancy and the registered head word.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {WORD_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + ADDR_W'(push_s);
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {CNT_W{1'b0}});
      head_r   <= head_next_s;
    end
  end

  assign oValid    = valid_r;
  assign oChannel  = head_r[ch_lsb_f(COARSE_W, FINE_W) +: CH_W];
  assign oCoarse   = head_r[coarse_lsb_f(FINE_W) +: COARSE_W];
  assign oFine     = head_r[fine_lsb_f() +: FINE_W];
  assign oOverflow = ovf_r;

endmodule

// File: tb/tb_tdc_multichan_stamper.sv
module tb_tdc_multichan_stamper;

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iEnable = 1'b0;
  logic [3:0]   iHit = 4'h0;
  logic [255:0] iTaps = '0;
  logic         oValid;
  logic         iReady = 1'b0;
  logic [1:0]   oChannel;
  logic [15:0]  oCoarse;
  logic [6:0]   oFine;
  logic         oOverflow;
  logic         iClrOvf = 1'b0;

  int checks = 0;
  int errors = 0;
  int tb_coarse = 0;

  int exp_ch [10];
  int exp_co [10];
  int exp_fi [10];
  int fc [4];
  int base;

  tdc_multichan_stamper dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iEnable   (iEnable),
    .iHit      (iHit),
    .iTaps     (iTaps),
    .oValid    (oValid),
    .iReady    (iReady),
    .oChannel  (oChannel),
    .oCoarse   (oCoarse),
    .oFine     (oFine),
    .oOverflow (oOverflow),
    .iClrOvf   (iClrOvf)
  );

  always #5 iClk = ~iClk;

  function automatic logic [63:0] ones(input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; reference coarse counter follows the same rule as the design.
  task automatic tick();
    @(posedge iClk);
    if (iRst_n && iEnable) tb_coarse = (tb_coarse + 1) & 16'hFFFF;
    #1;
  endtask

  task automatic do_reset();
    iRst_n = 1'b0; iEnable = 1'b0; iHit = 4'h0; iReady = 1'b0; iClrOvf = 1'b0; iTaps = '0;
    tb_coarse = 0;
    tick(); tick();
    iRst_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 70000 && tb_coarse != target; k++) tick();
  endtask

  task automatic chk_word(input string tag, input int ch, input int co, input int fi);
    chk({tag, " valid"}, oValid, 1);
    chk({tag, " ch"}, oChannel, ch);
    chk({tag, " coarse"}, oCoarse, co);
    chk({tag, " fine"}, oFine, fi);
  endtask

  initial begin
    // Reset state
    @(negedge iClk);
    do_reset();
    chk("rst valid", oValid, 0);
    chk("rst ch", oChannel, 0);
    chk("rst coarse", oCoarse, 0);
    chk("rst fine", oFine, 0);
    chk("rst ovf", oOverflow, 0);

    // Single hit: ch0 at coarse 20, 23 taps set
    iEnable = 1'b1;
    run_to(20);
    iTaps[0 +: 64] = ones(23);
    iHit = 4'b0001;
    tick();
    chk("single lat1 valid", oValid, 0);
    tick();
    chk_word("single", 0, 20, 23);
    iReady = 1'b1;
    tick();
    chk("single drained", oValid, 0);
    iHit = 4'h0; iReady = 1'b0;

    // All four channels at coarse 100
    do_reset();
    iEnable = 1'b1;
    run_to(100);
    for (int c = 0; c < 4; c++) iTaps[c*64 +: 64] = ones(8 * (c + 1));
    iHit = 4'hF;
    tick();
    tick();
    iReady = 1'b1;
    chk_word("all4 w0", 0, 100, 8);
    tick();
    chk_word("all4 w1", 1, 100, 16);
    tick();
    chk_word("all4 w2", 2, 100, 24);
    tick();
    chk_word("all4 w3", 3, 100, 32);
    tick();
    chk("all4 empty", oValid, 0);
    chk("all4 ovf", oOverflow, 0);
    iHit = 4'h0; iReady = 1'b0;

    // Backpressure: 10 edges, FIFO full, 2 pending, then overflow
    do_reset();
    iEnable = 1'b1;
    fc[0] = 3; fc[1] = 17; fc[2] = 40; fc[3] = 63;
    for (int c = 0; c < 4; c++) iTaps[c*64 +: 64] = ones(fc[c]);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      iHit = 4'b0001 << (i % 4);
      exp_ch[i] = i % 4;
      exp_co[i] = tb_coarse;
      exp_fi[i] = fc[i % 4];
      tick();
    end
    iHit = 4'h0;
    tick();
    chk("bp full valid", oValid, 1);
    chk("bp ovf before", oOverflow, 0);
    iTaps[0 +: 64] = ones(64);
    iHit = 4'b0001;
    tick();
    chk("bp ovf set", oOverflow, 1);
    iHit = 4'h0;
    tick();
    iHit = 4'b0001; iClrOvf = 1'b1;
    tick();
    chk("bp ovf beats clr", oOverflow, 1);
    iHit = 4'h0; iClrOvf = 1'b0;
    iReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_word($sformatf("bp w%0d", i), exp_ch[i], exp_co[i], exp_fi[i]);
      tick();
    end
    chk("bp drained", oValid, 0);
    iClrOvf = 1'b1;
    tick();
    chk("bp ovf cleared", oOverflow, 0);
    iClrOvf = 1'b0; iReady = 1'b0;

    // Coarse wrap: ch0 at 0xFFFF, ch1 next cycle at 0x0000
    do_reset();
    iEnable = 1'b1;
    run_to(16'hFFFF);
    iHit = 4'b0001;
    tick();
    iHit = 4'b0011;
    tick();
    chk_word("wrap w0", 0, 16'hFFFF, 0);
    iReady = 1'b1;
    tick();
    chk_word("wrap w1", 1, 16'h0000, 0);
    tick();
    chk("wrap empty", oValid, 0);
    iHit = 4'h0; iReady = 1'b0;

    // Fine encoding: all-zero, all-one, bubbled thermometer
    do_reset();
    iEnable = 1'b1;
    base = tb_coarse;
    iTaps[0 +: 64]   = 64'h0;
    iTaps[64 +: 64]  = ones(64);
    iTaps[128 +: 64] = 64'h7FFF_FFFF_FFFF_FBFF & ones(31);
    iHit = 4'b0111;
    tick();
    tick();
    chk_word("fine zero", 0, base, 0);
    iReady = 1'b1;
    tick();
    chk_word("fine full", 1, base, 64);
    tick();
    chk_word("fine bubble", 2, base, 30);
    tick();
    chk("fine empty", oValid, 0);
    iHit = 4'h0; iReady = 1'b0;

    // Reset with three words queued
    do_reset();
    iEnable = 1'b1;
    iHit = 4'b0111;
    tick(); tick(); tick(); tick();
    chk("mid queued", oValid, 1);
    iRst_n = 1'b0; iHit = 4'h0; tb_coarse = 0;
    #1;
    chk("mid rst valid", oValid, 0);
    chk("mid rst ch", oChannel, 0);
    chk("mid rst coarse", oCoarse, 0);
    chk("mid rst fine", oFine, 0);
    tick(); tick();
    iRst_n = 1'b1;
    iReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid post %0d", k), oValid, 0);
    end
    iTaps[192 +: 64] = ones(12);
    iHit = 4'b1000;
    base = tb_coarse;
    tick();
    tick();
    chk_word("mid new", 3, base, 12);
    chk("mid ovf", oOverflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
